// File: rtl/dispatch_router_pkg.sv
// Shared constants for the dispatch stage: lane sizes, channel IDs and an
// ordering helper used by the prefix checks.
package dispatch_router_pkg;

   localparam int unsigned LANE_SZ_RVC = 2;
   localparam int unsigned LANE_SZ_STD = 4;

   localparam int unsigned INTBLOCK_ID = 0;
   localparam int unsigned MEMBLOCK_ID = 1;

   // True when the set bits of v form a contiguous run starting at bit 0.
   function automatic logic is_prefix(input logic [31:0] v);
      return ((v + 32'd1) & v) == 32'd0;
   endfunction

endpackage

// Ordering check: the valid bits of a lane/port vector must be a prefix.
`define DISP_PREFIX_OK(v) dispatch_router_pkg::is_prefix(32'(v))

// File: rtl/disp_chan_queue.sv
// One dispatch queue: compacted multi-entry write at tail, in-order
// multi-entry read at head, wrap-flag pointers.
module disp_chan_queue #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned INPORT_NUM  = 4,
   parameter int unsigned OUTPORT_NUM = 4,
   parameter type         entry_t     = logic [63:0]
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [$clog2(INPORT_NUM+1)-1:0]      enq_num,
   input  entry_t [INPORT_NUM-1:0]              enq_entry,
   input  logic [$clog2(OUTPORT_NUM+1)-1:0]     deq_num,
   output logic [$clog2(DEPTH):0]               count,
   output logic [OUTPORT_NUM-1:0]               deq_vld,
   output entry_t [OUTPORT_NUM-1:0]             deq_entry
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   entry_t           mem_q [DEPTH];

   assign count = tail_q - head_q;

   // Pointer update; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         tail_q <= tail_q + PTR_W'(enq_num);
         head_q <= head_q + PTR_W'(deq_num);
      end
   end

   // Write the already-compacted lanes at tail, tail+1, ...
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         for (int i = 0; i < INPORT_NUM; i++) begin
            if (i < int'(enq_num)) begin
               mem_q[tail_q[IDX_W-1:0] + IDX_W'(i)] <= enq_entry[i];
            end
         end
      end
   end

   // Head view: entry head+k, valid while the queue holds more than k entries.
   always_comb begin
      for (int k = 0; k < OUTPORT_NUM; k++) begin
         deq_vld[k]   = count > PTR_W'(k);
         deq_entry[k] = mem_q[head_q[IDX_W-1:0] + IDX_W'(k)];
      end
   end

   a_no_underflow : assert property (@(posedge clk) disable iff (rst || flush)
      int'(deq_num) <= int'(count));
   a_no_overflow : assert property (@(posedge clk) disable iff (rst || flush)
      int'(count) + int'(enq_num) - int'(deq_num) <= int'(DEPTH));

endmodule

// File: rtl/dispatch_router.sv
// Dispatch stage: speculative PC tagging, per-channel lane compaction and
// routing into CHANNEL_NUM in-order dispatch queues.
module dispatch_router
   import dispatch_router_pkg::*;
#(
   parameter int unsigned     INPORT_NUM  = 4,
   parameter int unsigned     OUTPORT_NUM = 4,
   parameter int unsigned     CHANNEL_NUM = 2,
   parameter int unsigned     DEPTH       = 16,
   parameter int unsigned     DATA_W      = 64,
   parameter int unsigned     XLEN        = 64,
   parameter logic [XLEN-1:0] INIT_PC     = 'h8000_0000
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                i_squash_vld,
   input  logic [XLEN-1:0]                                     i_squash_pc,
   output logic                                                o_can_enq,
   input  logic [INPORT_NUM-1:0]                               i_enq_vld,
   input  logic [INPORT_NUM-1:0][$clog2(CHANNEL_NUM)-1:0]      i_enq_chan,
   input  logic [INPORT_NUM-1:0]                               i_enq_skip,
   input  logic [INPORT_NUM-1:0]                               i_enq_isRVC,
   input  logic [INPORT_NUM-1:0][DATA_W-1:0]                   i_enq_data,
   output logic [XLEN-1:0]                                     o_spec_pc,
   output logic [CHANNEL_NUM-1:0][OUTPORT_NUM-1:0]             o_deq_vld,
   output logic [CHANNEL_NUM-1:0][OUTPORT_NUM-1:0][DATA_W-1:0] o_deq_data,
   output logic [CHANNEL_NUM-1:0][OUTPORT_NUM-1:0][XLEN-1:0]   o_deq_pc,
   input  logic [CHANNEL_NUM-1:0][OUTPORT_NUM-1:0]             i_deq_ren
);

   localparam int unsigned CHAN_W = $clog2(CHANNEL_NUM);
   localparam int unsigned ACC_W  = $clog2(4 * INPORT_NUM + 1);
   localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
   localparam int unsigned ENQ_W  = $clog2(INPORT_NUM + 1);
   localparam int unsigned DEQ_W  = $clog2(OUTPORT_NUM + 1);
   localparam int unsigned LANE_W = (INPORT_NUM > 1) ? $clog2(INPORT_NUM) : 1;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [XLEN-1:0]                  base_q;
   logic [INPORT_NUM-1:0][XLEN-1:0]  lane_pc;
   logic [ACC_W-1:0]                 group_sz;
   logic                             accept;
   logic [PTR_W-1:0]                 chan_count [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0]           chan_room;
   entry_t [INPORT_NUM-1:0]          comp_entry [CHANNEL_NUM];
   logic [ENQ_W-1:0]                 comp_num   [CHANNEL_NUM];
   logic [DEQ_W-1:0]                 deq_num    [CHANNEL_NUM];

   // Running lane offsets: invalid lanes contribute 0, RVC 2, others 4.
   always_comb begin
      logic [ACC_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < INPORT_NUM; i++) begin
         lane_pc[i] = base_q + XLEN'(acc);
         if (i_enq_vld[i]) begin
            acc = acc + (i_enq_isRVC[i] ? ACC_W'(LANE_SZ_RVC) : ACC_W'(LANE_SZ_STD));
         end
      end
      group_sz = acc;
   end

   // Room check uses registered counts only, so a full group always fits.
   always_comb begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         chan_room[c] = chan_count[c] <= PTR_W'(DEPTH - INPORT_NUM);
      end
   end

   assign o_can_enq = &chan_room;
   assign accept    = o_can_enq && (|i_enq_vld) && !i_squash_vld;
   assign o_spec_pc = base_q;

   // Per-channel compaction of routed, non-skip lanes in lane order.
   always_comb begin
      logic [ENQ_W-1:0] n;
      n = '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         n             = '0;
         comp_entry[c] = '0;
         for (int i = 0; i < INPORT_NUM; i++) begin
            if (i_enq_vld[i] && !i_enq_skip[i] && (i_enq_chan[i] == CHAN_W'(c))) begin
               comp_entry[c][n[LANE_W-1:0]] = '{pc: lane_pc[i], data: i_enq_data[i]};
               n = n + ENQ_W'(1);
            end
         end
         comp_num[c] = accept ? n : '0;
      end
   end

   // Pop count per channel from the read-enable prefix.
   always_comb begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         deq_num[c] = '0;
         for (int k = 0; k < OUTPORT_NUM; k++) begin
            deq_num[c] = deq_num[c] + DEQ_W'(i_deq_ren[c][k]);
         end
      end
   end

   // PC base: squash restarts it, an accepted group advances it.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= INIT_PC;
      end else if (i_squash_vld) begin
         base_q <= i_squash_pc;
      end else if (accept) begin
         base_q <= base_q + XLEN'(group_sz);
      end
   end

   for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_chan
      entry_t [OUTPORT_NUM-1:0] head_entry;

      disp_chan_queue #(
         .DEPTH       (DEPTH),
         .INPORT_NUM  (INPORT_NUM),
         .OUTPORT_NUM (OUTPORT_NUM),
         .entry_t     (entry_t)
      ) u_queue (
         .clk       (clk),
         .rst       (rst),
         .flush     (i_squash_vld),
         .enq_num   (comp_num[c]),
         .enq_entry (comp_entry[c]),
         .deq_num   (deq_num[c]),
         .count     (chan_count[c]),
         .deq_vld   (o_deq_vld[c]),
         .deq_entry (head_entry)
      );

      for (genvar k = 0; k < OUTPORT_NUM; k++) begin : g_port
         assign o_deq_data[c][k] = head_entry[k].data;
         assign o_deq_pc[c][k]   = head_entry[k].pc;
      end

      a_ren_prefix : assert property (@(posedge clk) disable iff (rst)
         `DISP_PREFIX_OK(i_deq_ren[c]));
      a_ren_subset : assert property (@(posedge clk) disable iff (rst)
         (i_deq_ren[c] & ~o_deq_vld[c]) == '0);
   end

   a_vld_prefix : assert property (@(posedge clk) disable iff (rst)
      `DISP_PREFIX_OK(i_enq_vld));

   for (genvar i = 0; i < INPORT_NUM; i++) begin : g_lane_chk
      a_chan_range : assert property (@(posedge clk) disable iff (rst)
         (i_enq_vld[i] && !i_enq_skip[i]) |-> (32'(i_enq_chan[i]) < CHANNEL_NUM));
   end

endmodule
